// File: rtl/car_drive_if.sv
// Controller/plant bus for car_drive_unit: command inputs and vehicle status outputs.
interface car_drive_if;
    logic        accelerate_car;
    logic        unlock_doors;
    logic        door_open_req;
    logic [7:0]  car_speed;
    logic        moving;
    logic        doors_unlocked;
    logic        door_open;
    logic        protocol_err;
    logic [15:0] odometer;

    // Controller / testbench side
    modport master (
        output accelerate_car, unlock_doors, door_open_req,
        input  car_speed, moving, doors_unlocked, door_open, protocol_err, odometer
    );

    // Vehicle model side
    modport slave (
        input  accelerate_car, unlock_doors, door_open_req,
        output car_speed, moving, doors_unlocked, door_open, protocol_err, odometer
    );
endinterface

// File: rtl/car_drive_unit.sv
// car_drive_unit: vehicle-side plant for the cruise controller.
// Prescaled speed integrator with clamp, door-lock interlock FSM and a sticky
// illegal-command flag. Optional distance accumulator built only when
// CAR_ODOMETER_EN is defined; otherwise odometer is tied to zero.
module car_drive_unit #(
    parameter logic [7:0]  ACCEL_STEP = 8'd2,
    parameter logic [7:0]  DECEL_STEP = 8'd3,
    parameter int unsigned TICK_DIV   = 4,
    parameter logic [7:0]  MAX_SPEED  = 8'd200
) (
    input  logic         clk,
    input  logic         rst,
    car_drive_if.slave   bus
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        DOOR_LOCKED   = 2'd0,
        DOOR_UNLOCKED = 2'd1,
        DOOR_OPEN     = 2'd2
    } door_state_t;

    logic [CNT_W-1:0] presc_q;
    logic             tick;
    logic [7:0]       speed_q;
    logic [7:0]       speed_d;
    logic [8:0]       accel_sum;
    logic             accel_ok;
    logic             err_cond;
    logic             err_q;
    door_state_t      door_q;
    door_state_t      door_d;
    logic             unlocked_c;
    logic             open_c;

    assign tick = (presc_q == CNT_W'(TICK_DIV - 1));

    // Prescaler: free-running 0..TICK_DIV-1 counter
    always_ff @(posedge clk) begin
        if (rst)       presc_q <= '0;
        else if (tick) presc_q <= '0;
        else           presc_q <= presc_q + CNT_W'(1);
    end

    // Acceleration allowed only for a clean command with the doors locked
    assign accel_ok = bus.accelerate_car && !bus.unlock_doors && (door_q == DOOR_LOCKED);
    assign err_cond = bus.accelerate_car && (bus.unlock_doors || (door_q != DOOR_LOCKED));
    assign accel_sum = {1'b0, speed_q} + {1'b0, ACCEL_STEP};

    // Next speed: clamped accelerate or floor-at-zero decelerate
    always_comb begin
        speed_d = 8'd0;
        if (accel_ok) begin
            speed_d = (accel_sum > {1'b0, MAX_SPEED}) ? MAX_SPEED : accel_sum[7:0];
        end else if (speed_q >= DECEL_STEP) begin
            speed_d = speed_q - DECEL_STEP;
        end
    end

    // Speed register, updated on prescaler ticks only
    always_ff @(posedge clk) begin
        if (rst)       speed_q <= 8'd0;
        else if (tick) speed_q <= speed_d;
    end

    // Sticky protocol error flag
    always_ff @(posedge clk) begin
        if (rst)           err_q <= 1'b0;
        else if (err_cond) err_q <= 1'b1;
    end

    // Door FSM state register
    always_ff @(posedge clk) begin
        if (rst) door_q <= DOOR_LOCKED;
        else     door_q <= door_d;
    end

    // Door FSM next-state: unlock waits for standstill, open must close first
    always_comb begin
        door_d = door_q;
        case (door_q)
            DOOR_LOCKED: begin
                if (bus.unlock_doors && (speed_q == 8'd0)) door_d = DOOR_UNLOCKED;
            end
            DOOR_UNLOCKED: begin
                if (bus.door_open_req)      door_d = DOOR_OPEN;
                else if (!bus.unlock_doors) door_d = DOOR_LOCKED;
            end
            DOOR_OPEN: begin
                if (!bus.door_open_req) door_d = DOOR_UNLOCKED;
            end
            default: door_d = DOOR_LOCKED;
        endcase
    end

    // Door FSM output decode from registered state
    always_comb begin
        unlocked_c = 1'b0;
        open_c     = 1'b0;
        case (door_q)
            DOOR_UNLOCKED: unlocked_c = 1'b1;
            DOOR_OPEN: begin
                unlocked_c = 1'b1;
                open_c     = 1'b1;
            end
            default: begin
                unlocked_c = 1'b0;
                open_c     = 1'b0;
            end
        endcase
    end

`ifdef CAR_ODOMETER_EN
    logic [15:0] odo_q;

    // Distance accumulator: adds the freshly computed speed on each tick
    always_ff @(posedge clk) begin
        if (rst)       odo_q <= 16'd0;
        else if (tick) odo_q <= odo_q + 16'(speed_d);
    end

    assign bus.odometer = odo_q;
`else
    assign bus.odometer = 16'd0;
`endif

    assign bus.car_speed      = speed_q;
    assign bus.moving         = (speed_q != 8'd0);
    assign bus.doors_unlocked = unlocked_c;
    assign bus.door_open      = open_c;
    assign bus.protocol_err   = err_q;

endmodule

// File: tb/tb_car_drive_unit.sv
// Scoreboard bench for car_drive_unit: stimulus queues expected output values
// tagged with the cycle they must hold; a negedge monitor pops and compares.
module tb_car_drive_unit;

    logic clk;
    logic rst;
    int unsigned cyc;
    int unsigned n_tests;
    int unsigned n_fail;

    localparam int unsigned S_SPEED  = 0;
    localparam int unsigned S_MOVING = 1;
    localparam int unsigned S_UNLOCK = 2;
    localparam int unsigned S_OPEN   = 3;
    localparam int unsigned S_ERR    = 4;
    localparam int unsigned S_ODO    = 5;

    typedef struct {
        int unsigned cyc;
        int unsigned sel;
        logic [15:0] val;
    } exp_t;

    exp_t exp_q[$];

    car_drive_if bus ();

    car_drive_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sel_name(input int unsigned s);
        case (s)
            S_SPEED:  return "car_speed";
            S_MOVING: return "moving";
            S_UNLOCK: return "doors_unlocked";
            S_OPEN:   return "door_open";
            S_ERR:    return "protocol_err";
            default:  return "odometer";
        endcase
    endfunction

    function automatic logic [15:0] sample(input int unsigned s);
        case (s)
            S_SPEED:  return {8'd0, bus.car_speed};
            S_MOVING: return {15'd0, bus.moving};
            S_UNLOCK: return {15'd0, bus.doors_unlocked};
            S_OPEN:   return {15'd0, bus.door_open};
            S_ERR:    return {15'd0, bus.protocol_err};
            default:  return bus.odometer;
        endcase
    endfunction

    // Monitor: compare every expectation due this cycle, flag stale ones
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            logic [15:0] act;
            e = exp_q.pop_front();
            n_tests++;
            if (e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)",
                         sel_name(e.sel), e.cyc, cyc);
            end else begin
                act = sample(e.sel);
                if (act !== e.val) begin
                    n_fail++;
                    $display("FAIL %s @cycle %0d: got %0d, expected %0d",
                             sel_name(e.sel), cyc, act, e.val);
                end
            end
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_now(input int unsigned sel, input logic [15:0] v);
        exp_t e;
        e.cyc = cyc;
        e.sel = sel;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic expect_idle_outputs();
        expect_now(S_SPEED, 16'd0);
        expect_now(S_MOVING, 16'd0);
        expect_now(S_UNLOCK, 16'd0);
        expect_now(S_OPEN, 16'd0);
        expect_now(S_ERR, 16'd0);
        expect_now(S_ODO, 16'd0);
    endtask

    initial begin
        logic [7:0] coast [5];
        logic [15:0] odo_ramp;
        coast = '{8'd17, 8'd14, 8'd11, 8'd8, 8'd5};
`ifdef CAR_ODOMETER_EN
        odo_ramp = 16'd110;
`else
        odo_ramp = 16'd0;
`endif
        cyc = 0;
        n_tests = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.accelerate_car = 1'b0;
        bus.unlock_doors   = 1'b0;
        bus.door_open_req  = 1'b0;

        // Reset for two cycles
        step(2);
        rst = 1'b0;
        expect_idle_outputs();

        // First tick with no commands keeps speed at zero
        step(4);
        expect_now(S_SPEED, 16'd0);

        // Ramp: 10 ticks of +2
        bus.accelerate_car = 1'b1;
        step(4);
        expect_now(S_SPEED, 16'd2);
        expect_now(S_MOVING, 16'd1);
        step(36);
        expect_now(S_SPEED, 16'd20);
        expect_now(S_ODO, odo_ramp);

        // Coast down to 5
        bus.accelerate_car = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(3);
            expect_now(S_SPEED, (i == 0) ? 16'd20 : {8'd0, coast[i-1]});
            step(1);
            expect_now(S_SPEED, {8'd0, coast[i]});
        end

        // Unlock request while moving is held off until standstill
        bus.unlock_doors = 1'b1;
        step(4);
        expect_now(S_SPEED, 16'd2);
        expect_now(S_MOVING, 16'd1);
        expect_now(S_UNLOCK, 16'd0);
        step(4);
        expect_now(S_SPEED, 16'd0);
        expect_now(S_MOVING, 16'd0);
        expect_now(S_UNLOCK, 16'd0);
        step(1);
        expect_now(S_UNLOCK, 16'd1);
        expect_now(S_OPEN, 16'd0);

        // Open the door, then drop unlock: door stays open
        bus.door_open_req = 1'b1;
        step(1);
        expect_now(S_OPEN, 16'd1);
        expect_now(S_UNLOCK, 16'd1);
        bus.unlock_doors = 1'b0;
        step(3);
        expect_now(S_OPEN, 16'd1);
        expect_now(S_UNLOCK, 16'd1);

        // Close the door, then relock
        bus.door_open_req = 1'b0;
        step(1);
        expect_now(S_OPEN, 16'd0);
        expect_now(S_UNLOCK, 16'd1);
        step(1);
        expect_now(S_UNLOCK, 16'd0);
        expect_now(S_ERR, 16'd0);

        // Saturation at MAX_SPEED
        bus.accelerate_car = 1'b1;
        step(500);
        expect_now(S_SPEED, 16'd200);
        step(8);
        expect_now(S_SPEED, 16'd200);

        // Reset mid-operation from full speed
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        expect_now(S_SPEED, 16'd0);
        expect_now(S_ODO, 16'd0);

        // Ramp to 10, then illegal command on a tick edge
        step(20);
        expect_now(S_SPEED, 16'd10);
        step(3);
        bus.unlock_doors = 1'b1;
        step(1);
        bus.unlock_doors   = 1'b0;
        bus.accelerate_car = 1'b0;
        expect_now(S_SPEED, 16'd7);
        expect_now(S_ERR, 16'd1);
        expect_now(S_UNLOCK, 16'd0);
        step(4);
        expect_now(S_SPEED, 16'd4);
        expect_now(S_ERR, 16'd1);

        // Reset clears the sticky error and speed
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        expect_now(S_ERR, 16'd0);
        expect_now(S_SPEED, 16'd0);

        // Accelerating while unlocked is also illegal
        bus.unlock_doors = 1'b1;
        step(1);
        expect_now(S_UNLOCK, 16'd1);
        expect_now(S_ERR, 16'd0);
        bus.unlock_doors   = 1'b0;
        bus.accelerate_car = 1'b1;
        step(1);
        bus.accelerate_car = 1'b0;
        expect_now(S_ERR, 16'd1);
        expect_now(S_UNLOCK, 16'd0);
        expect_now(S_SPEED, 16'd0);

        // Drain scoreboard with a bounded wait
        step(3);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
